// File: rtl/mem_port_arbiter_pkg.sv
// Shared widths and FSM state encoding for the memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_REL  = 2'd2
    } state_t;

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// Two-way grant selection with a registered priority pointer.
// On contention the pointer decides; it flips only after a contended grant.
module rr_arbiter2 #(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic       gnt_valid,
    output logic       gnt_port
);

    // Port that wins the next contended grant.
    logic prio_q;
    logic prio_d;

    // Grant selection and pointer update.
    always_comb begin
        gnt_valid = |req;
        gnt_port  = 1'b0;
        prio_d    = prio_q;
        if (&req) begin
            gnt_port = ROUND_ROBIN ? prio_q : 1'b0;
        end else begin
            gnt_port = req[1];
        end
        if (ROUND_ROBIN && grant_en && (&req)) begin
            prio_d = ~gnt_port;
        end
    end

    // Priority pointer register; port 0 is favoured out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one word-addressed memory bus between instruction fetch (port 0)
// and data access (port 1), converting per-port req/done into the memory's
// four-phase strobe/ack handshake, with an optional ack timeout.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter bit ROUND_ROBIN    = 1'b1,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              done0,
    output logic              done1,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_out,
    input  logic [DATA_W-1:0] mem_data_in,
    input  logic              mem_ack,
    output logic              busy,
    output logic              timeout_err
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              gnt_q, gnt_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_dout_q, mem_dout_d;
    logic [DATA_W-1:0] rdata_q [2];
    logic [DATA_W-1:0] rdata_d [2];
    logic [1:0]        done_q, done_d;
    logic              terr_q, terr_d;

    logic              gnt_valid;
    logic              gnt_port;
    logic              grant_en;
    logic              sel_we;
    logic [CNT_W-1:0]  cnt_inc;
    logic              timeout_hit;

    assign grant_en = (state_q == ST_IDLE) && gnt_valid;

    rr_arbiter2 #(
        .ROUND_ROBIN (ROUND_ROBIN)
    ) u_rr (
        .clk       (clk),
        .reset     (reset),
        .req       ({req1, req0}),
        .grant_en  (grant_en),
        .gnt_valid (gnt_valid),
        .gnt_port  (gnt_port)
    );

    // Timeout compares the counter value after this cycle's increment, so a
    // strobe is held for exactly TIMEOUT_CYCLES cycles before an abort.
    assign cnt_inc     = cnt_q + CNT_W'(1);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == CNT_W'(TIMEOUT_CYCLES));
    assign sel_we      = gnt_port ? we1 : we0;

    // Next-state, handshake and datapath updates.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_dout_d  = mem_dout_q;
        rdata_d[0]  = rdata_q[0];
        rdata_d[1]  = rdata_q[1];
        done_d      = 2'b00;
        terr_d      = terr_q;

        case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    gnt_d       = gnt_port;
                    mem_read_d  = ~sel_we;
                    mem_write_d = sel_we;
                    mem_addr_d  = gnt_port ? addr1 : addr0;
                    mem_dout_d  = gnt_port ? wdata1 : wdata0;
                    cnt_d       = '0;
                    state_d     = ST_REQ;
                end
            end
            ST_REQ: begin
                cnt_d = cnt_inc;
                if (mem_ack) begin
                    if (mem_read_q) begin
                        rdata_d[gnt_q] = mem_data_in;
                    end
                    done_d[gnt_q] = 1'b1;
                    mem_read_d    = 1'b0;
                    mem_write_d   = 1'b0;
                    cnt_d         = '0;
                    state_d       = ST_REL;
                end else if (timeout_hit) begin
                    rdata_d[gnt_q] = '0;
                    done_d[gnt_q]  = 1'b1;
                    mem_read_d     = 1'b0;
                    mem_write_d    = 1'b0;
                    terr_d         = 1'b1;
                    cnt_d          = '0;
                    state_d        = ST_REL;
                end
            end
            ST_REL: begin
                cnt_d = cnt_inc;
                if (!mem_ack) begin
                    state_d = ST_IDLE;
                end else if (timeout_hit) begin
                    terr_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                state_d     = ST_REL;
            end
        endcase
    end

    // State and datapath registers; reset lands in REL so a memory cycle
    // interrupted by reset is allowed to drain its ack before any new grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_REL;
            cnt_q       <= '0;
            gnt_q       <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_dout_q  <= '0;
            rdata_q[0]  <= '0;
            rdata_q[1]  <= '0;
            done_q      <= 2'b00;
            terr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_dout_q  <= mem_dout_d;
            rdata_q[0]  <= rdata_d[0];
            rdata_q[1]  <= rdata_d[1];
            done_q      <= done_d;
            terr_q      <= terr_d;
        end
    end

    assign rdata0       = rdata_q[0];
    assign rdata1       = rdata_q[1];
    assign done0        = done_q[0];
    assign done1        = done_q[1];
    assign mem_read     = mem_read_q;
    assign mem_write    = mem_write_q;
    assign mem_addr     = mem_addr_q;
    assign mem_data_out = mem_dout_q;
    assign busy         = (state_q != ST_IDLE);
    assign timeout_err  = terr_q;

endmodule
